// File: rtl/sb_arbiter_pkg.sv
// Shared types for the system-bus arbiter: FSM states, bus owner and the fixed fetch byte mask.
package sb_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } sb_state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } sb_owner_t;

   localparam logic [3:0] FETCH_BYTE_MASK = 4'hF;

   // Data wins unless fetch has already sat through a full streak of data grants.
   function automatic sb_owner_t pick_owner(input logic data_pending,
                                            input logic fetch_req,
                                            input logic streak_full);
      return (data_pending && !(fetch_req && streak_full)) ? OWN_DATA : OWN_FETCH;
   endfunction

endpackage

// File: rtl/sb_arbiter.sv
// Shares the single system-bus port between instruction fetch and data load/store,
// one transaction in flight, with bounded fetch starvation and a bus timeout.
module sb_arbiter
   import sb_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STREAK_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              d_re_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [3:0]        d_byte_mask_i,
   input  logic              d_un_sign_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_valid_o,
   output logic              hold_o,
   output logic              err_o,
   output logic              sb_req_o,
   output logic              sb_we_o,
   output logic [ADDR_W-1:0] sb_addr_o,
   output logic [DATA_W-1:0] sb_wdata_o,
   output logic [3:0]        sb_byte_mask_o,
   output logic              sb_un_sign_o,
   input  logic              sb_gnt_i,
   input  logic              sb_rvalid_i,
   input  logic [DATA_W-1:0] sb_rdata_i
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int STK_W = $clog2(STREAK_MAX + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [STK_W-1:0] STK_FULL = STK_W'(STREAK_MAX);

   sb_state_t         state, state_nxt;
   sb_owner_t         owner_q, owner_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        mask_q;
   logic              we_q;
   logic              un_sign_q;
   logic              err_q;
   logic [TMR_W-1:0]  timer_q;
   logic [STK_W-1:0]  streak_q;
   logic              data_pending;
   logic              timer_last;
   logic              launch;
   logic              abort;

   assign data_pending = d_re_i | d_we_i;
   assign timer_last   = (timer_q == TMR_LAST);
   assign owner_nxt    = pick_owner(data_pending, if_req_i, streak_q == STK_FULL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // DONE always returns to IDLE so a request still held during its own completion is not re-issued.
   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (if_req_i || data_pending) begin
               launch    = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (sb_gnt_i) begin
               state_nxt = ST_WAIT;
            end else if (timer_last) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (sb_rvalid_i) begin
               state_nxt = ST_DONE;
            end else if (timer_last) begin
               abort     = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request fields are captured only at launch; a load with both strobes set becomes a store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q   <= OWN_FETCH;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         mask_q    <= '0;
         we_q      <= 1'b0;
         un_sign_q <= 1'b0;
         err_q     <= 1'b0;
         timer_q   <= '0;
         streak_q  <= '0;
      end else if (launch) begin
         owner_q <= owner_nxt;
         timer_q <= '0;
         err_q   <= 1'b0;
         if (owner_nxt == OWN_DATA) begin
            addr_q    <= d_addr_i;
            we_q      <= d_we_i;
            wdata_q   <= d_we_i ? d_wdata_i : '0;
            mask_q    <= d_byte_mask_i;
            un_sign_q <= d_un_sign_i;
            if (!if_req_i)                streak_q <= '0;
            else if (streak_q != STK_FULL) streak_q <= streak_q + 1'b1;
         end else begin
            addr_q    <= if_addr_i;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= FETCH_BYTE_MASK;
            un_sign_q <= 1'b0;
            streak_q  <= '0;
         end
      end else if (state == ST_REQ || state == ST_WAIT) begin
         timer_q <= timer_q + 1'b1;
         if (state == ST_WAIT && sb_rvalid_i) begin
            rdata_q <= we_q ? '0 : sb_rdata_i;
         end else if (abort) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   assign sb_req_o       = (state == ST_REQ);
   assign sb_we_o        = sb_req_o & we_q;
   assign sb_addr_o      = sb_req_o ? addr_q : '0;
   assign sb_wdata_o     = sb_req_o ? wdata_q : '0;
   assign sb_byte_mask_o = sb_req_o ? mask_q : '0;
   assign sb_un_sign_o   = sb_req_o & un_sign_q;

   assign if_valid_o = (state == ST_DONE) && (owner_q == OWN_FETCH);
   assign d_valid_o  = (state == ST_DONE) && (owner_q == OWN_DATA);
   assign if_rdata_o = if_valid_o ? rdata_q : '0;
   assign d_rdata_o  = d_valid_o ? rdata_q : '0;
   assign err_o      = (state == ST_DONE) && err_q;

   assign hold_o = (if_req_i & ~if_valid_o) | (data_pending & ~d_valid_o);

endmodule
